// File: rtl/instr_loader.sv
// Byte-stream program loader for the instruction memory load port.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic        write_enable,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t      state_r, next_state_s;
  logic [7:0]  cnt_lo_r;
  logic [15:0] count_r;
  logic [15:0] word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_r;
  logic [31:0] write_address_r, write_data_r;
  logic        write_enable_r, cpu_hold_r, done_r, error_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  logic        rx_ready_s, take_s, start_ok_s;
  logic [15:0] count_s, idx_next_s;

  assign rx_ready_s = (state_r == S_CNT0) || (state_r == S_CNT1) ||
                      (state_r == S_DATA) || (state_r == S_CHK);
  assign take_s     = rx_valid && rx_ready_s;
  assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) ||
                                (state_r == S_ERR));
  assign count_s    = {rx_data, cnt_lo_r};
  assign idx_next_s = word_idx_r + 16'd1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state_s = S_CNT0;
        else       next_state_s = state_r;
      end
      S_CNT0: begin
        if (take_s) next_state_s = S_CNT1;
        else        next_state_s = state_r;
      end
      S_CNT1: begin
        if (!take_s)                       next_state_s = state_r;
        else if ({1'b0, count_s} > DEPTH_W) next_state_s = S_ERR;
        else if (count_s == 16'd0)          next_state_s = S_TAIL;
        else                                next_state_s = S_DATA;
      end
      S_DATA: begin
        if (take_s && (byte_idx_r == 2'd3)) next_state_s = S_WRITE;
        else                                next_state_s = state_r;
      end
      S_WRITE: begin
        if (idx_next_s == count_r) next_state_s = S_TAIL;
        else                       next_state_s = S_DATA;
      end
      S_CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (!take_s)                next_state_s = state_r;
        else if (rx_data == csum_r) next_state_s = S_DONE;
        else                        next_state_s = S_ERR;
`else
        next_state_s = S_IDLE;
`endif
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Count capture, word assembly and write-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo_r        <= 8'd0;
      count_r         <= 16'd0;
      word_idx_r      <= 16'd0;
      byte_idx_r      <= 2'd0;
      word_r          <= 24'd0;
      write_address_r <= 32'd0;
      write_data_r    <= 32'd0;
      write_enable_r  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_r          <= 8'd0;
`endif
    end else begin
      write_enable_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_idx_r <= 2'd0;
            word_idx_r <= 16'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
          end
        end
        S_CNT0: if (take_s) cnt_lo_r <= rx_data;
        S_CNT1: if (take_s) count_r  <= count_s;
        S_DATA: begin
          if (take_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r     <= csum_r ^ rx_data;
`endif
            case (byte_idx_r)
              2'd0:    word_r[7:0]   <= rx_data;
              2'd1:    word_r[15:8]  <= rx_data;
              2'd2:    word_r[23:16] <= rx_data;
              default: begin
                // Registered so the strobe lines up with the WRITE state
                write_data_r    <= {rx_data, word_r};
                write_address_r <= BASE_ADDR + {16'd0, word_idx_r};
                write_enable_r  <= 1'b1;
              end
            endcase
          end
        end
        S_WRITE: word_idx_r <= idx_next_s;
        default: ;
      endcase
    end
  end

  // Core hold and sticky completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else if ((next_state_s == S_DONE) && (state_r != S_DONE)) begin
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b1;
    end else if ((next_state_s == S_ERR) && (state_r != S_ERR)) begin
      cpu_hold_r <= 1'b0;
      error_r    <= 1'b1;
    end else if (start_ok_s) begin
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end
  end

  assign rx_ready      = rx_ready_s;
  assign write_address = write_address_r;
  assign write_data    = write_data_r;
  assign write_enable  = write_enable_r;
  assign cpu_hold      = cpu_hold_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a driver streams loads, a monitor checks
// every write strobe against a queue of expected (address, data) pairs.
module tb_instr_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, write_enable, cpu_hold, done, error;
  logic [31:0] write_address, write_data;

  instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .write_address(write_address),
    .write_data(write_data), .write_enable(write_enable),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [7:0]  stream_q[$];
  logic [31:0] words[$];
  int          checks = 0, errors = 0;
  bit          exp_done, exp_err;
  logic [31:0] last_addr = 32'd0, last_data = 32'd0;
  bit          prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next expected write; ports hold otherwise
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (write_enable) begin
        chk("we_not_back_to_back", prev_we, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_address", write_address, e.a);
          chk("write_data", write_data, e.d);
          last_addr = e.a;
          last_data = e.d;
        end
      end else begin
        chk("address_hold", write_address, last_addr);
        chk("data_hold", write_data, last_data);
      end
      prev_we = write_enable;
    end
  end

  // Reference model: byte stream, expected writes and final status for a load
  task automatic prepare(input int n, input logic [7:0] cs_xor);
    logic [7:0] x;
    logic [31:0] w;
    wr_t e;
    x = 8'h00;
    stream_q.delete();
    stream_q.push_back(n[7:0]);
    stream_q.push_back(n[15:8]);
    if (n > DEPTH) begin
      exp_err = 1'b1; exp_done = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int b = 0; b < 4; b++) begin
          stream_q.push_back(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
        e.a = BASE + 32'(i);
        e.d = w;
        exp_q.push_back(e);
      end
      if (CS != 0) begin
        stream_q.push_back(x ^ cs_xor);
        exp_err = (cs_xor != 8'h00); exp_done = !exp_err;
      end else begin
        exp_err = 1'b0; exp_done = 1'b1;
      end
    end
  endtask

  task automatic run_load(input int vmode, input bit abort, input int glitch_at,
                          output int cycles, output bit timed_out);
    int rdy_bad;
    bit v;
    rdy_bad = 0;
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b0;
    cycles = 0; timed_out = 1'b1;
    while (cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = (cycles == glitch_at);
      if (cycles == 1) chk("hold_rise", cpu_hold, 1'b1);
      if (done || error) begin timed_out = 1'b0; break; end
      if (abort && stream_q.size() == 0) begin timed_out = 1'b0; break; end
      if (rx_ready == write_enable) rdy_bad++;
      case (vmode)
        0:       v = 1'b1;
        1:       v = cycles[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (stream_q.size() == 0) v = 1'b0;
      rx_valid = v;
      rx_data  = v ? stream_q[0] : 8'($urandom);
      if (v && rx_ready) void'(stream_q.pop_front());
    end
    start = 1'b0; rx_valid = 1'b0;
    chk("ready_low_only_in_write", rdy_bad, 0);
  endtask

  task automatic do_load(input string tag, input int n, input logic [7:0] csx,
                         input int vmode, input int glitch);
    int cycles;
    bit to;
    prepare(n, csx);
    run_load(vmode, 1'b0, glitch, cycles, to);
    chk({tag, "_timeout"}, to, 1'b0);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_hold_low"}, cpu_hold, 1'b0);
    chk({tag, "_ready_low"}, rx_ready, 1'b0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    if (vmode == 0) chk({tag, "_cycles"}, cycles, (n > DEPTH) ? 3 : 3 + 5*n + CS);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_write_address"}, write_address, 32'd0);
    chk({tag, "_write_data"}, write_data, 32'd0);
    chk({tag, "_write_enable"}, write_enable, 1'b0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int cycles, n, vm;
    bit to;
    logic [7:0] csx;
    repeat (3) @(negedge clk);
    last_addr = 32'd0; last_data = 32'd0;
    check_reset_outputs("reset");
    reset = 1'b0;

    words = '{32'h00100113, 32'h00208193};
    do_load("plan_n2", 2, 8'h00, 0, 0);
    do_load("over_depth", DEPTH + 1, 8'h00, 0, 0);
    do_load("count_256", 256, 8'h00, 0, 0);
    words = '{32'hDEADBEEF};
    do_load("toggle_valid", 1, 8'h00, 1, 0);

    // Abort mid-word: only count plus two data bytes are delivered
    words = '{32'hCAFEF00D};
    prepare(1, 8'h00);
    while (stream_q.size() > 4) void'(stream_q.pop_back());
    exp_q.delete();
    run_load(0, 1'b1, 0, cycles, to);
    chk("abort_timeout", to, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    last_addr = 32'd0; last_data = 32'd0;
    check_reset_outputs("midword_reset");
    reset = 1'b0;
    words = '{32'h12345678};
    do_load("after_reset", 1, 8'h00, 0, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    words = '{32'h00000093};
    do_load("cs_good", 1, 8'h00, 0, 0);
    do_load("cs_bad", 1, 8'h93, 0, 0);
`endif

    words = '{32'hA5A5_0001, 32'h5A5A_0002};
    do_load("start_in_data", 2, 8'h00, 0, 5);
    do_load("n_zero", 0, 8'h00, 0, 0);

    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    do_load("n_depth", DEPTH, 8'h00, 2, 0);

    for (int it = 0; it < 10; it++) begin
      words.delete();
      n  = $urandom_range(0, 8);
      vm = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      csx = ((CS != 0) && ($urandom_range(0, 3) == 0)) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_load("random", n, csx, vm, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the instruction memory's load port. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and issues one write-enable pulse per word at consecutive word addresses. While loading it holds the core via `cpu_hold`, and it reports completion or failure to the boot/debug controller.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory depth in words; maximum accepted word count.
- `BASE_ADDR`, 0: word index written by the first instruction.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  single-cycle pulse; begins a load when the FSM is in IDLE.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `rx_valid && rx_ready`.
- `write_address`  out  32  word index to the instruction memory, zero-extended.
- `write_data`  out  32  assembled instruction word.
- `write_enable`  out  1  one-cycle write strobe.
- `cpu_hold`  out  1  core stall/reset request; high from `start` until DONE or ERR.
- `done`  out  1  load completed successfully; sticky until the next `start` or `reset`.
- `error`  out  1  load aborted; sticky until the next `start` or `reset`.

## Operation
- FSM states: IDLE, CNT0, CNT1, DATA, WRITE, CHK, DONE, ERR.
- IDLE: `start` moves to CNT0, sets `cpu_hold`, and clears `done`/`error`, the byte index, the word index and the checksum.
- CNT0/CNT1: accept the low byte, then the high byte, of the 16-bit word count N.
- After CNT1:
  - N > DEPTH goes to ERR.
  - N == 0 goes to CHK if checksum is compiled in, else to DONE.
  - Otherwise go to DATA.
- DATA: accept 4 bytes, little-endian; byte 0 goes to bits [7:0]. After the 4th byte, go to WRITE.
- WRITE: for one cycle drive `write_enable`=1, `write_address`=BASE_ADDR+word index, and the assembled `write_data`. Then increment the word index. If the index equals N, go to CHK or DONE; otherwise return to DATA.
- DONE/ERR: `cpu_hold`=0 and `done`/`error` are held high. `start` re-enters CNT0, so a new load overwrites the old image.
- `start` in any state other than IDLE, DONE or ERR is ignored.
- Address arithmetic: 32-bit wrap. BASE_ADDR+N-1 beyond DEPTH-1 is not checked; the memory decodes only the low index bits.
- Reset at any point, including mid-word: return to IDLE immediately. The partial word is discarded and no write is issued.

## Timing
- Reset values: `rx_ready`=0, `write_address`=0, `write_data`=0, `write_enable`=0, `cpu_hold`=0, `done`=0, `error`=0.
- `rx_ready` is 1 exactly in CNT0, CNT1, DATA and CHK. It is combinational from state and does not depend on `rx_valid`.
- `rx_ready` is 0 during the WRITE cycle, so there is a one-cycle bubble per word.
- Minimum load time with `rx_valid` held high: 1 (start) + 2 + 5N (+1 with checksum) cycles until DONE.
- `cpu_hold` rises the cycle after `start` and falls in the same cycle `done` or `error` rises.
- `write_enable` is never high for two consecutive cycles.
- `write_address` and `write_data` hold their last values outside WRITE.
- `rx_valid` low stalls the FSM in its current state with no timeout. Bytes presented while `rx_ready`=0 are not consumed.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - An extra CHK state accepts one trailing byte after the last word, or directly after the count when N==0.
  - The trailing byte must equal the XOR of all data bytes; the count bytes are excluded. Match goes to DONE, mismatch goes to ERR.
  - Words already written are not rolled back.
- Not defined: CHK and the checksum register are absent, and the last WRITE goes straight to DONE.

## Test plan
- Reset, then N=2 with words 0x00100113 and 0x00208193 sent as bytes 02 00 13 01 10 00 93 81 20 00 → exactly two `write_enable` pulses: addr 0 data 0x00100113, then addr 1 data 0x00208193. Then `done`=1, `cpu_hold`=0, and total time is 13 cycles from start.
- Count bytes 41 00 (N=65, DEPTH=64) → `error`=1, no write strobe, `rx_ready`=0 afterwards.
- N=1 with `rx_valid` toggling every other cycle → a single write of the correct word. `rx_ready` drops only in the WRITE cycle and no byte is lost or duplicated.
- Reset asserted after 2 of 4 data bytes → all outputs return to reset values and no write occurs. A fresh load then writes from BASE_ADDR.
- With `INSTR_LOADER_CHECKSUM_EN`, N=1, word 0x00000093 and checksum 0x93 → `done`=1. The same load with checksum 0x00 → the write still occurs, then `error`=1 and `done`=0.
- `start` pulsed in the middle of DATA is ignored. N=0 without the macro → DONE 3 cycles after start, with no write.
